// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader slice.
//   led_state_t   : per-channel fade FSM state (OFF/UP/ON/DOWN, 2 bits)
//   DEF_*         : default parameter values used by the fader and its channels
package led_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } led_state_t;

  localparam int unsigned DEF_NUM_LED   = 2;
  localparam int unsigned DEF_PWM_BITS  = 8;
  localparam int unsigned DEF_PRESCALE  = 4;
  localparam int unsigned DEF_RAMP_STEP = 16;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel of the PWM fader: fade FSM, duty register and PWM comparator.
// Ports:
//   clk, resetN  : system clock, asynchronous active-low reset
//   req          : synchronised LED request, active-high (1 = LED wanted on)
//   fade_en      : 1 = ramp transitions, 0 = instant on/off
//   max_duty     : ON-state duty
//   period_end   : single-clk flag on the last clk of each PWM period
//   pwm_cnt      : shared PWM counter
//   led_n        : registered PWM drive, active-low
//   busy         : registered, high while the channel is UP or DOWN
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                req,
  input  logic                fade_en,
  input  logic [PWM_BITS-1:0] max_duty,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_n,
  output logic                busy
);

  localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(RAMP_STEP);

  led_state_t          state;
  logic [PWM_BITS-1:0] duty;

  // Ramp arithmetic is done one bit wider so the step can never wrap the duty.
  logic [PWM_BITS:0]   duty_ext;
  logic [PWM_BITS:0]   max_ext;
  logic [PWM_BITS:0]   sum_ext;
  logic [PWM_BITS:0]   diff_ext;
  logic [PWM_BITS-1:0] up_duty;
  logic [PWM_BITS-1:0] down_duty;

  always_comb begin
    duty_ext  = {1'b0, duty};
    max_ext   = {1'b0, max_duty};
    sum_ext   = duty_ext + STEP_EXT;
    diff_ext  = duty_ext - STEP_EXT;
    // Saturating at max_duty also clamps a duty left above a lowered max_duty.
    up_duty   = (sum_ext > max_ext) ? max_duty : sum_ext[PWM_BITS-1:0];
    down_duty = (duty_ext > STEP_EXT) ? diff_ext[PWM_BITS-1:0] : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_OFF;
      duty  <= '0;
      led_n <= 1'b1;
      busy  <= 1'b0;
    end else begin
      led_n <= ~(pwm_cnt < duty);

      unique case (state)
        ST_OFF: begin
          if (req) begin
            if (fade_en) begin
              state <= ST_UP;
              busy  <= 1'b1;
            end else begin
              state <= ST_ON;
              duty  <= max_duty;
            end
          end
        end

        ST_UP: begin
          if (!req) begin
            state <= ST_DOWN;
          end else if (period_end) begin
            duty <= up_duty;
            if (up_duty == max_duty) begin
              state <= ST_ON;
              busy  <= 1'b0;
            end
          end
        end

        ST_ON: begin
          if (!req) begin
            if (fade_en) begin
              state <= ST_DOWN;
              busy  <= 1'b1;
            end else begin
              state <= ST_OFF;
              duty  <= '0;
            end
          end else if (period_end) begin
            duty <= max_duty;
          end
        end

        ST_DOWN: begin
          if (req) begin
            state <= ST_UP;
          end else if (period_end) begin
            duty <= down_duty;
            if (down_duty == '0) begin
              state <= ST_OFF;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_OFF;
          duty  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader downstream of the LED blink pattern generator. Synchronises the
// active-low pattern bits into clk, runs a shared prescaler and PWM counter,
// and drives one fading channel per LED.
// Ports:
//   clk, resetN      : system clock, asynchronous active-low reset
//   i_led_n          : requested LED state, active-low, asynchronous to clk
//   i_fade_en        : 1 = ramp transitions, 0 = instant on/off
//   i_max_duty       : ON-state duty, quasi-static
//   o_led_n          : registered PWM LED drive, active-low
//   o_busy           : per-channel, high while ramping (UP or DOWN)
//   o_period_strobe  : one-clk pulse at each PWM period end
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned NUM_LED   = DEF_NUM_LED,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned PRESCALE  = DEF_PRESCALE,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [NUM_LED-1:0]  i_led_n,
  input  logic                i_fade_en,
  input  logic [PWM_BITS-1:0] i_max_duty,
  output logic [NUM_LED-1:0]  o_led_n,
  output logic [NUM_LED-1:0]  o_busy,
  output logic                o_period_strobe
);

  localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [NUM_LED-1:0]  sync1;
  logic [NUM_LED-1:0]  sync2;
  logic [NUM_LED-1:0]  req;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                step;
  logic                period_end;

  // Two-flop synchroniser; idles at 1 so every LED starts requested off.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_led_n;
      sync2 <= sync1;
    end
  end

  assign req        = ~sync2;
  assign step       = (pre_cnt == PRE_LAST);
  assign period_end = step & (&pwm_cnt);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pre_cnt         <= '0;
      pwm_cnt         <= '0;
      o_period_strobe <= 1'b0;
    end else begin
      pre_cnt         <= step ? '0 : pre_cnt + PRE_W'(1);
      o_period_strobe <= period_end;
      if (step) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .resetN     (resetN),
      .req        (req[g]),
      .fade_en    (i_fade_en),
      .max_duty   (i_max_duty),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt),
      .led_n      (o_led_n[g]),
      .busy       (o_busy[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed fade scenarios plus a random
// phase, every clk compared against a time-based behavioural model.
module tb_led_pwm_fader;

  localparam int NL     = 2;
  localparam int PRE    = 4;
  localparam int STEPD  = 16;
  localparam int LEVELS = 256;
  localparam int PERIOD = PRE * LEVELS;

  localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DOWN = 3;

  logic          clk;
  logic          resetN;
  logic [NL-1:0] i_led_n;
  logic          i_fade_en;
  logic [7:0]    i_max_duty;
  logic [NL-1:0] o_led_n;
  logic [NL-1:0] o_busy;
  logic          o_period_strobe;

  led_pwm_fader #(
    .NUM_LED   (NL),
    .PWM_BITS  (8),
    .PRESCALE  (PRE),
    .RAMP_STEP (STEPD)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .i_led_n         (i_led_n),
    .i_fade_en       (i_fade_en),
    .i_max_duty      (i_max_duty),
    .o_led_n         (o_led_n),
    .o_busy          (o_busy),
    .o_period_strobe (o_period_strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: channel state/duty, request pipeline, clk edges since reset release.
  int            m_st   [NL];
  int            m_duty [NL];
  logic [NL-1:0] m_s1, m_s2;
  int            cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_st[i]   = M_OFF;
      m_duty[i] = 0;
    end
    m_s1 = '1;
    m_s2 = '1;
    cyc  = 0;
  endtask

  // One clk: advance the model across the edge, then compare all outputs.
  task automatic tick();
    logic [NL-1:0] req, exp_led, exp_busy;
    bit pe;
    int pwm, md, nd;
    @(posedge clk);
    pe  = (cyc % PERIOD) == PERIOD - 1;
    pwm = (cyc / PRE) % LEVELS;
    md  = int'(i_max_duty);
    req = ~m_s2;
    for (int i = 0; i < NL; i++) begin
      exp_led[i] = (pwm < m_duty[i]) ? 1'b0 : 1'b1;
      case (m_st[i])
        M_OFF:
          if (req[i]) begin
            if (i_fade_en) m_st[i] = M_UP;
            else begin m_st[i] = M_ON; m_duty[i] = md; end
          end
        M_UP:
          if (!req[i]) m_st[i] = M_DOWN;
          else if (pe) begin
            nd = (m_duty[i] + STEPD < md) ? m_duty[i] + STEPD : md;
            m_duty[i] = nd;
            if (nd == md) m_st[i] = M_ON;
          end
        M_ON:
          if (!req[i]) begin
            if (i_fade_en) m_st[i] = M_DOWN;
            else begin m_st[i] = M_OFF; m_duty[i] = 0; end
          end else if (pe) m_duty[i] = md;
        default:
          if (req[i]) m_st[i] = M_UP;
          else if (pe) begin
            nd = (m_duty[i] > STEPD) ? m_duty[i] - STEPD : 0;
            m_duty[i] = nd;
            if (nd == 0) m_st[i] = M_OFF;
          end
      endcase
    end
    m_s2 = m_s1;
    m_s1 = i_led_n;
    cyc++;
    #1;
    for (int i = 0; i < NL; i++)
      exp_busy[i] = (m_st[i] == M_UP) || (m_st[i] == M_DOWN);
    check_val("led_n", 32'(o_led_n), 32'(exp_led));
    check_val("busy", 32'(o_busy), 32'(exp_busy));
    check_val("strobe", 32'(o_period_strobe), pe ? 32'd1 : 32'd0);
  endtask

  task automatic wait_phase(input int pos);
    for (int k = 0; k < PERIOD && (cyc % PERIOD) != pos; k++) tick();
  endtask

  // Count strobes from now until busy[ch] falls (inclusive of that clk).
  task automatic count_ramp(input int ch, input string tag, input int exp_n);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 20 * PERIOD && !done; k++) begin
      tick();
      if (o_period_strobe) n++;
      if (!o_busy[ch] && n > 0) done = 1;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_periods"}, 32'(n), 32'(exp_n));
  endtask

  task automatic count_on(input int ch, input string tag, input int exp_n);
    int n = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      if (!o_led_n[ch]) n++;
    end
    check_val(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_reset();
    #2 resetN = 1'b0;
    #1;
    check_val("rst_led_n", 32'(o_led_n), 32'h3);
    check_val("rst_busy", 32'(o_busy), 32'h0);
    check_val("rst_strobe", 32'(o_period_strobe), 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    int n, b, want;
    bit hit;
    resetN     = 1'b0;
    i_led_n    = 2'b11;
    i_fade_en  = 1'b0;
    i_max_duty = 8'd128;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("init_led_n", 32'(o_led_n), 32'h3);
    check_val("init_busy", 32'(o_busy), 32'h0);
    resetN = 1'b1;

    // Idle: LEDs dark, strobe once per 1024 clk.
    n = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      tick();
      if (o_period_strobe) n++;
    end
    check_val("idle_strobes", 32'(n), 32'd2);

    // Instant on at max_duty 128: half of every period lit.
    i_led_n[0] = 1'b0;
    repeat (10) tick();
    count_on(0, "instant_on_lit", 512);

    // Full fade up at max_duty 255.
    i_led_n[0] = 1'b1;
    repeat (10) tick();
    i_fade_en  = 1'b1;
    i_max_duty = 8'd255;
    wait_phase(100);
    i_led_n[0] = 1'b0;
    count_ramp(0, "fade_up", 16);
    count_on(0, "full_on_lit", 255 * PRE);

    // Reversal at duty 96: six periods back down to OFF.
    i_fade_en  = 1'b0;
    i_led_n[0] = 1'b1;
    repeat (10) tick();
    i_fade_en = 1'b1;
    wait_phase(100);
    i_led_n[0] = 1'b0;
    hit = 0;
    for (int k = 0; k < 10 * PERIOD && !hit; k++) begin
      tick();
      hit = (m_duty[0] == 96);
    end
    check_val("rev_reach96", 32'(hit), 32'd1);
    i_led_n[0] = 1'b1;
    count_ramp(0, "fade_down", 6);

    // Lower max_duty while ch1 is at 160 in UP: clamps to 64 at next period end.
    wait_phase(100);
    i_led_n[1] = 1'b0;
    hit = 0;
    for (int k = 0; k < 12 * PERIOD && !hit; k++) begin
      tick();
      hit = (m_duty[1] == 160);
    end
    check_val("ch1_reach160", 32'(hit), 32'd1);
    i_max_duty = 8'd64;
    count_ramp(1, "clamp", 1);
    repeat (10) tick();
    count_on(1, "clamp_lit", 64 * PRE);

    // Random phase: requests, fade mode and max_duty change under the model.
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(299) == 0) begin
        b = $urandom_range(NL - 1);
        i_led_n[b] = ~i_led_n[b];
      end
      if ($urandom_range(1999) == 0) i_fade_en = ~i_fade_en;
      if ($urandom_range(4999) == 0) i_max_duty = 8'($urandom_range(255));
      tick();
    end

    // Reset in the middle of a fade.
    i_fade_en  = 1'b1;
    i_max_duty = 8'd200;
    i_led_n    = 2'b11;
    repeat (10) tick();
    i_led_n = 2'b00;
    repeat (3000) tick();
    want = 0;
    for (int i = 0; i < NL; i++) if (m_st[i] == M_UP) want++;
    check_val("pre_rst_ramping", 32'(want), 32'd2);
    i_led_n = 2'b11;
    do_reset();
    repeat (40) tick();
    check_val("post_rst_busy", 32'(o_busy), 32'h0);
    check_val("post_rst_led_n", 32'(o_led_n), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
